mvm_packetizer: RTL and testbench



---
 rtl/mvm_packetizer.sv | 190 +++++++++++++++++++
 tb/tb_mvm_packetizer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mvm_packetizer.sv
`default_nettype none
// ==========================================================================
// Module : mvm_packetizer
// Host AXIS ingress: strips header beats, tags payload with dest/op, and
// emits NoC packets through a 2-entry skid buffer. Stats via PKTZ_STATS_EN.
// Rev    : 1.0
// ==========================================================================
module mvm_packetizer #(
  parameter int TDATAW = 512,
  parameter int DESTW  = 4,
  parameter int USERW  = 2,
  parameter int LENW   = 10
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              AXIS_S_TVALID,
  output logic              AXIS_S_TREADY,
  input  logic [TDATAW-1:0] AXIS_S_TDATA,
  input  logic              AXIS_S_TLAST,
  output logic              AXIS_M_TVALID,
  input  logic              AXIS_M_TREADY,
  output logic [TDATAW-1:0] AXIS_M_TDATA,
  output logic              AXIS_M_TLAST,
  output logic [USERW-1:0]  AXIS_M_TUSER,
  output logic [DESTW-1:0]  AXIS_M_TDEST,
  output logic              ERR
`ifdef PKTZ_STATS_EN
  ,
  output logic [31:0]       PKT_CNT,
  output logic [15:0]       ERR_CNT
`endif
);

  localparam int EW = TDATAW + 1 + USERW + DESTW;

  localparam logic [0:0] ST_HDR     = 1'b0;
  localparam logic [0:0] ST_PAYLOAD = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [DESTW-1:0] dest_q, dest_d;
  logic [USERW-1:0] op_q, op_d;
  logic [LENW-1:0]  len_q, len_d;
  logic [LENW-1:0]  cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             tready_q, tready_d;
  logic [1:0]       count_q, count_d;
  logic [EW-1:0]    ent0_q, ent1_q;

  logic             s_hs;
  logic             push;
  logic             pop;
  logic             at_end;
  logic [EW-1:0]    push_ent;
  logic [DESTW-1:0] hdr_dest;
  logic [USERW-1:0] hdr_op;
  logic [LENW-1:0]  hdr_len;

  assign hdr_dest = AXIS_S_TDATA[DESTW-1:0];
  assign hdr_op   = AXIS_S_TDATA[DESTW+USERW-1:DESTW];
  assign hdr_len  = AXIS_S_TDATA[DESTW+USERW+LENW-1:DESTW+USERW];

  assign s_hs     = AXIS_S_TVALID & tready_q;
  assign push     = s_hs & (state_q == ST_PAYLOAD);
  assign pop      = (count_q != 2'd0) & AXIS_M_TREADY;
  assign at_end   = (cnt_q == (len_q - LENW'(1)));
  assign push_ent = {AXIS_S_TDATA, at_end | AXIS_S_TLAST, op_q, dest_q};

  always_comb begin
    state_d = state_q;
    dest_d  = dest_q;
    op_d    = op_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    case (state_q)
      ST_HDR: begin
        if (s_hs) begin
          if (hdr_len == '0) begin
            err_d = 1'b1;
          end else begin
            dest_d  = hdr_dest;
            op_d    = hdr_op;
            len_d   = hdr_len;
            cnt_d   = '0;
            state_d = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (s_hs) begin
          cnt_d = cnt_q + LENW'(1);
          // Length reached or host ended early; a mismatch of the two is an error.
          if (at_end | AXIS_S_TLAST) begin
            state_d = ST_HDR;
            err_d   = at_end ^ AXIS_S_TLAST;
          end
        end
      end
      default: state_d = ST_HDR;
    endcase
  end

  always_comb begin
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    // Headers never occupy the buffer, so the host may always send one.
    tready_d = (state_d == ST_HDR) | (count_d != 2'd2);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= ST_HDR;
      dest_q   <= '0;
      op_q     <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      tready_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      state_q  <= state_d;
      dest_q   <= dest_d;
      op_q     <= op_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      tready_q <= tready_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ent0_q <= '0;
      ent1_q <= '0;
    end else if (pop) begin
      if (push) begin
        if (count_q == 2'd2) begin
          ent0_q <= ent1_q;
          ent1_q <= push_ent;
        end else begin
          ent0_q <= push_ent;
        end
      end else begin
        ent0_q <= ent1_q;
      end
    end else if (push) begin
      if (count_q == 2'd0) begin
        ent0_q <= push_ent;
      end else begin
        ent1_q <= push_ent;
      end
    end
  end

  assign AXIS_S_TREADY = tready_q;
  assign AXIS_M_TVALID = (count_q != 2'd0);
  assign AXIS_M_TDATA  = ent0_q[EW-1 -: TDATAW];
  assign AXIS_M_TLAST  = ent0_q[USERW+DESTW];
  assign AXIS_M_TUSER  = ent0_q[USERW+DESTW-1:DESTW];
  assign AXIS_M_TDEST  = ent0_q[DESTW-1:0];
  assign ERR           = err_q;

`ifdef PKTZ_STATS_EN
  logic [31:0] pkt_cnt_q;
  logic [15:0] err_cnt_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pkt_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      if (pop & AXIS_M_TLAST) begin
        pkt_cnt_q <= pkt_cnt_q + 32'd1;
      end
      if (err_d & (err_cnt_q != 16'hFFFF)) begin
        err_cnt_q <= err_cnt_q + 16'd1;
      end
    end
  end

  assign PKT_CNT = pkt_cnt_q;
  assign ERR_CNT = err_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mvm_packetizer.sv
`default_nettype none
// Directed bench for mvm_packetizer: scoreboarded M beats, ERR pulse count,
// skid occupancy model and hold-stability checks.
module tb_mvm_packetizer;
  localparam int TDATAW = 512;
  localparam int DESTW  = 4;
  localparam int USERW  = 2;
  localparam int LENW   = 10;
  localparam int CW     = TDATAW + 8;

  typedef struct packed {
    logic [TDATAW-1:0] data;
    logic              last;
    logic [USERW-1:0]  user;
    logic [DESTW-1:0]  dest;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [TDATAW-1:0] s_data = '0;
  logic              s_last = 1'b0;
  logic              m_valid;
  logic              m_ready = 1'b1;
  logic [TDATAW-1:0] m_data;
  logic              m_last;
  logic [USERW-1:0]  m_user;
  logic [DESTW-1:0]  m_dest;
  logic              err;
`ifdef PKTZ_STATS_EN
  logic [31:0]       pkt_cnt;
  logic [15:0]       err_cnt;
`endif

  int    n_checks = 0;
  int    n_errors = 0;
  int    err_seen = 0;
  int    occ = 0;
  int    tready_lo = 0;
  logic  rdy_const = 1'b1;
  logic  rdy_mode = 1'b0;
  logic  occ_en = 1'b0;
  logic  pay_flag = 1'b0;
  logic  hold_prev = 1'b0;
  beat_t prev_beat;
  beat_t got_q[$];
  beat_t exp_q[$];

  always #5 clk = ~clk;

  mvm_packetizer #(
    .TDATAW(TDATAW), .DESTW(DESTW), .USERW(USERW), .LENW(LENW)
  ) dut (
    .CLK          (clk),
    .RST_N        (rst_n),
    .AXIS_S_TVALID(s_valid),
    .AXIS_S_TREADY(s_ready),
    .AXIS_S_TDATA (s_data),
    .AXIS_S_TLAST (s_last),
    .AXIS_M_TVALID(m_valid),
    .AXIS_M_TREADY(m_ready),
    .AXIS_M_TDATA (m_data),
    .AXIS_M_TLAST (m_last),
    .AXIS_M_TUSER (m_user),
    .AXIS_M_TDEST (m_dest),
    .ERR          (err)
`ifdef PKTZ_STATS_EN
    ,
    .PKT_CNT      (pkt_cnt),
    .ERR_CNT      (err_cnt)
`endif
  );

  task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [TDATAW-1:0] pd(input int t, input int i);
    logic [31:0] w;
    w = 32'(t * 65536 + i);
    return {16{w}};
  endfunction

  function automatic logic [TDATAW-1:0] hdr(input int d, input int op, input int len);
    logic [TDATAW-1:0] h;
    h = '0;
    h[TDATAW-1 -: 32] = 32'hDEADBEEF;
    h[DESTW-1:0] = DESTW'(d);
    h[DESTW+USERW-1:DESTW] = USERW'(op);
    h[DESTW+USERW+LENW-1:DESTW+USERW] = LENW'(len);
    return h;
  endfunction

  task automatic exp_push(input logic [TDATAW-1:0] d, input logic l, input int u, input int de);
    beat_t b;
    b.data = d;
    b.last = l;
    b.user = USERW'(u);
    b.dest = DESTW'(de);
    exp_q.push_back(b);
  endtask

  task automatic send(input logic [TDATAW-1:0] d, input logic l);
    int n = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    @(negedge clk);
    while (!s_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) check("s_handshake_timeout", CW'(s_ready), CW'(1));
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic start_test();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    got_q.delete();
    exp_q.delete();
    err_seen = 0;
    tready_lo = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic finish_test(input string tag, input int exp_errs, input int exp_pkts);
    int n = 0;
    while (m_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_drain"}, CW'(m_valid), CW'(0));
    repeat (3) @(negedge clk);
    check({tag, "_nbeats"}, CW'(got_q.size()), CW'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check($sformatf("%s_beat%0d", tag, i), CW'(got_q[i]), CW'(exp_q[i]));
    end
    check({tag, "_err_pulses"}, CW'(err_seen), CW'(exp_errs));
`ifdef PKTZ_STATS_EN
    check({tag, "_pkt_cnt"}, CW'(pkt_cnt), CW'(exp_pkts));
    check({tag, "_err_cnt"}, CW'(err_cnt), CW'(exp_errs));
`else
    if (exp_pkts < 0) check({tag, "_pkts_arg"}, CW'(exp_pkts), CW'(0));
`endif
  endtask

  // M_TREADY source: constant level or the repeating 1,0,0,1 pattern.
  initial begin
    int ph = 0;
    forever begin
      @(posedge clk);
      #2;
      if (rdy_mode) begin
        m_ready = (ph == 0) || (ph == 3);
        ph = (ph + 1) % 4;
      end else begin
        m_ready = rdy_const;
        ph = 0;
      end
    end
  end

  always @(negedge clk) begin
    beat_t cur;
    int push_i;
    int pop_i;
    cur = '{m_data, m_last, m_user, m_dest};
    if (!rst_n) begin
      hold_prev = 1'b0;
      occ = 0;
    end else begin
      if (m_valid && m_ready) got_q.push_back(cur);
      if (err) err_seen++;
      if (hold_prev) begin
        check("hold_valid", CW'(m_valid), CW'(1));
        check("hold_fields", CW'(cur), CW'(prev_beat));
      end
      hold_prev = m_valid && !m_ready;
      prev_beat = cur;
      if (occ_en) begin
        if (!s_ready) tready_lo++;
        check("s_tready_occ", CW'(s_ready), CW'(!pay_flag || occ != 2));
        check("m_tvalid_occ", CW'(m_valid), CW'(occ != 0));
        push_i = (s_valid && s_ready && pay_flag) ? 1 : 0;
        pop_i  = (m_valid && m_ready) ? 1 : 0;
        occ = occ + push_i - pop_i;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_s_tready", CW'(s_ready), CW'(0));
    check("rst_m_tvalid", CW'(m_valid), CW'(0));
    check("rst_m_fields", CW'({m_data, m_last, m_user, m_dest}), CW'(0));
    check("rst_err", CW'(err), CW'(0));
`ifdef PKTZ_STATS_EN
    check("rst_pkt_cnt", CW'(pkt_cnt), CW'(0));
    check("rst_err_cnt", CW'(err_cnt), CW'(0));
`endif
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("s_tready_after_rst", CW'(s_ready), CW'(1));

    // Normal packet, one-cycle latency and header bubble
    send(hdr(3, 3, 4), 1'b0);
    check("hdr_bubble", CW'(m_valid), CW'(0));
    send(pd(1, 0), 1'b0);
    check("lat_valid", CW'(m_valid), CW'(1));
    check("lat_data", CW'(m_data), CW'(pd(1, 0)));
    send(pd(1, 1), 1'b0);
    send(pd(1, 2), 1'b0);
    send(pd(1, 3), 1'b1);
    for (int i = 0; i < 4; i++) exp_push(pd(1, i), i == 3, 3, 3);
    finish_test("t1", 0, 1);

    // Zero-length header dropped, then a one-beat packet
    start_test();
    send(hdr(2, 1, 0), 1'b0);
    send(hdr(1, 0, 1), 1'b0);
    send(pd(2, 0), 1'b1);
    exp_push(pd(2, 0), 1'b1, 0, 1);
    finish_test("t2", 1, 1);

    // Truncated packet, next beat is a header
    start_test();
    send(hdr(5, 2, 5), 1'b0);
    send(pd(3, 0), 1'b0);
    send(pd(3, 1), 1'b1);
    send(hdr(7, 1, 1), 1'b0);
    send(pd(3, 2), 1'b1);
    exp_push(pd(3, 0), 1'b0, 2, 5);
    exp_push(pd(3, 1), 1'b1, 2, 5);
    exp_push(pd(3, 2), 1'b1, 1, 7);
    finish_test("t3", 1, 2);

    // Overrun: length reached without host TLAST
    start_test();
    send(hdr(9, 0, 2), 1'b0);
    send(pd(7, 0), 1'b0);
    send(pd(7, 1), 1'b0);
    send(hdr(2, 3, 1), 1'b1);
    send(pd(7, 2), 1'b1);
    exp_push(pd(7, 0), 1'b0, 0, 9);
    exp_push(pd(7, 1), 1'b1, 0, 9);
    exp_push(pd(7, 2), 1'b1, 3, 2);
    finish_test("t3b", 1, 2);

    // Backpressure 1,0,0,1 on a len=8 packet
    start_test();
    rdy_mode = 1'b1;
    occ_en = 1'b1;
    send(hdr(10, 1, 8), 1'b0);
    pay_flag = 1'b1;
    for (int i = 0; i < 8; i++) send(pd(4, i), i == 7);
    pay_flag = 1'b0;
    for (int i = 0; i < 8; i++) exp_push(pd(4, i), i == 7, 1, 10);
    finish_test("t4", 0, 1);
    check("t4_tready_dropped", CW'(tready_lo > 0), CW'(1));
    occ_en = 1'b0;
    rdy_mode = 1'b0;

    // Reset mid-packet with beats stuck in the buffer
    start_test();
    rdy_const = 1'b0;
    send(hdr(4, 2, 6), 1'b0);
    send(pd(5, 0), 1'b0);
    send(pd(5, 1), 1'b0);
    check("t5_buffered", CW'(m_valid), CW'(1));
    rst_n = 1'b0;
    #1;
    check("t5_rst_m_tvalid", CW'(m_valid), CW'(0));
    check("t5_rst_s_tready", CW'(s_ready), CW'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rdy_const = 1'b1;
    @(posedge clk);
    #1;
    send(hdr(6, 0, 2), 1'b0);
    send(pd(6, 0), 1'b0);
    send(pd(6, 1), 1'b1);
    exp_push(pd(6, 0), 1'b0, 0, 6);
    exp_push(pd(6, 1), 1'b1, 0, 6);
    finish_test("t5", 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
